// File: rtl/uart_rx_ctrl_gen2.sv
// ============================================================================
// uart_rx_ctrl_gen2 : oversampling UART receiver, 2-of-3 mid-bit voting,
//                     parity / stop / break status pulses.   rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_ctrl_gen2 #(
  parameter int MAX_DATA_W = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_len,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [MAX_DATA_W-1:0] rx_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  break_det,
  output logic                  busy
);

  // Counter width must hold the minimum prescale of 8 even for narrow prescale ports.
  localparam int            CW        = (PRESCALE_W > 4) ? PRESCALE_W : 4;
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_MIN_P   = CW'(8);
  localparam logic [3:0]    C_MAX_LEN = 4'(MAX_DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP_A = 3'd4,
    STOP_B = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         edge_cnt, p_lat, half;
  logic [3:0]            bit_cnt, len_lat;
  logic                  pe_lat, pt_lat, s2_lat;
  logic                  par_flag, stp_flag, brk_flag, par_bit;
  logic [2:0]            smp;
  logic [MAX_DATA_W-1:0] shreg;
  logic                  last_edge, maj, start_frame, brk_a;

  assign half      = p_lat >> 1;
  assign last_edge = (edge_cnt == p_lat - C_ONE);
  assign maj       = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  // Break seen at the end of the first stop bit: everything so far was low.
  assign brk_a     = (shreg == '0) && !(pe_lat && par_bit) && !maj;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    start_frame = 1'b0;
    data_valid  = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;
    break_det   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          state_nx    = START;
          start_frame = 1'b1;
        end
      end
      START:  if (last_edge) state_nx = maj ? IDLE : DATA;
      DATA:   if (last_edge && bit_cnt == len_lat - 4'd1) state_nx = pe_lat ? PARITY : STOP_A;
      PARITY: if (last_edge) state_nx = STOP_A;
      STOP_A: if (last_edge) state_nx = s2_lat ? STOP_B : DONE;
      STOP_B: if (last_edge) state_nx = DONE;
      DONE: begin
        data_valid = !par_flag && !stp_flag && !brk_flag;
        par_err    = par_flag;
        stp_err    = stp_flag || brk_flag;
        break_det  = brk_flag;
        // A low line in DONE is the first cycle of the next start bit.
        if (!RX_IN) begin
          state_nx    = START;
          start_frame = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      p_lat    <= C_MIN_P;
      len_lat  <= C_MAX_LEN;
      pe_lat   <= 1'b0;
      pt_lat   <= 1'b0;
      s2_lat   <= 1'b0;
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
      brk_flag <= 1'b0;
      par_bit  <= 1'b0;
      smp      <= '0;
      shreg    <= '0;
      rx_data  <= '0;
    end else begin
      if (start_frame) begin
        edge_cnt <= C_ONE;
        bit_cnt  <= '0;
        p_lat    <= (CW'(prescale) < C_MIN_P) ? C_MIN_P : CW'(prescale);
        len_lat  <= (data_len < 4'd5 || data_len > C_MAX_LEN) ? C_MAX_LEN : data_len;
        pe_lat   <= PAR_EN;
        pt_lat   <= PAR_TYP;
        s2_lat   <= STOP2;
        par_flag <= 1'b0;
        stp_flag <= 1'b0;
        brk_flag <= 1'b0;
        par_bit  <= 1'b0;
        shreg    <= '0;
      end else if (state == IDLE || state == DONE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        edge_cnt <= last_edge ? '0 : edge_cnt + C_ONE;
        if (edge_cnt == half - C_ONE) smp[0] <= RX_IN;
        if (edge_cnt == half)         smp[1] <= RX_IN;
        if (edge_cnt == half + C_ONE) smp[2] <= RX_IN;
        if (last_edge) begin
          bit_cnt <= (state == DATA && state_nx == DATA) ? bit_cnt + 4'd1 : 4'd0;
          case (state)
            DATA: begin
              for (int i = 0; i < MAX_DATA_W; i++)
                if (bit_cnt == 4'(i)) shreg[i] <= maj;
            end
            PARITY: begin
              par_bit <= maj;
              if (maj != (^shreg ^ pt_lat)) par_flag <= 1'b1;
            end
            STOP_A: begin
              if (!maj)  stp_flag <= 1'b1;
              if (brk_a) brk_flag <= 1'b1;
            end
            STOP_B: if (!maj) stp_flag <= 1'b1;
            default: ;
          endcase
        end
      end
      // Payload becomes visible in the DONE cycle; a break keeps the old value.
      if (state_nx == DONE && !((state == STOP_A) ? brk_a : brk_flag))
        rx_data <= shreg;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl_gen2.sv
// ============================================================================
// tb_uart_rx_ctrl_gen2 : directed + randomized bench with line-level frame model.
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl_gen2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic [3:0] data_len = 4'd8;
  logic       PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
  logic [7:0] rx_data;
  logic       data_valid, par_err, stp_err, break_det, busy;

  uart_rx_ctrl_gen2 #(.MAX_DATA_W(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale), .data_len(data_len),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .rx_data(rx_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .break_det(break_det), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0] pr;
    logic [3:0] dl;
    logic       pe, pt, s2;
  } cfg_t;

  typedef struct packed {
    int         cyc;
    logic [7:0] data;
    logic       dv, pe, se, bd;
  } ev_t;

  int   tests = 0;
  int   fails = 0;
  bit   rec = 1'b0;
  logic line_q[$];
  cfg_t cfg_q[$];
  ev_t  dut_q[$];
  ev_t  exp_q[$];
  logic [7:0] model_rx = 8'h00;

  // Per-cycle record of the line, the config inputs and any status pulse.
  always @(negedge CLK) begin
    if (rec) begin
      if (data_valid || par_err || stp_err || break_det)
        dut_q.push_back('{line_q.size(), rx_data, data_valid, par_err, stp_err, break_det});
      line_q.push_back(RX_IN);
      cfg_q.push_back('{prescale, data_len, PAR_EN, PAR_TYP, STOP2});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic bitv(input int s, input int k, input int p);
    int b = s + k * p + p / 2;
    int n = int'(line_q[b-1]) + int'(line_q[b]) + int'(line_q[b+1]);
    return (n >= 2);
  endfunction

  // Frame decoder working directly on the recorded line samples.
  task automatic run_model();
    int t = 0;
    int n = line_q.size();
    exp_q.delete();
    while (t < n) begin
      if (line_q[t] !== 1'b0) begin
        t++;
      end else begin
        cfg_t c = cfg_q[t];
        int s = t;
        int p = (c.pr < 6'd8) ? 8 : int'(c.pr);
        int l = (c.dl < 4'd5 || c.dl > 4'd8) ? 8 : int'(c.dl);
        int nb = 2 + l + int'(c.pe) + int'(c.s2);
        int d = s + nb * p;
        logic [7:0] pay = 8'h00;
        logic pbit, st1, st2, pf, sf, brk;
        if (s + p >= n) break;
        if (bitv(s, 0, p)) begin
          t = s + p;
          continue;
        end
        if (d >= n) break;
        for (int i = 0; i < l; i++) pay[i] = bitv(s, 1 + i, p);
        pbit = c.pe ? bitv(s, 1 + l, p) : 1'b0;
        st1  = bitv(s, 1 + l + int'(c.pe), p);
        st2  = c.s2 ? bitv(s, 2 + l + int'(c.pe), p) : 1'b1;
        pf   = c.pe && (pbit != ((^pay) ^ c.pt));
        sf   = !st1 || !st2;
        brk  = (pay == 8'h00) && !pbit && !st1;
        if (!brk) model_rx = pay;
        exp_q.push_back('{d, model_rx, !pf && !sf, pf, sf || brk, brk});
        t = d;
      end
    end
  endtask

  task automatic compare(input string tag);
    int m;
    tests++;
    assert (dut_q.size() == exp_q.size()) else begin
      fails++;
      $error("FAIL %s event count: got %0d expected %0d", tag, dut_q.size(), exp_q.size());
    end
    m = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      tests++;
      assert (dut_q[i] === exp_q[i]) else begin
        fails++;
        $error("FAIL %s ev%0d: got cyc=%0d data=%h dv/pe/se/bd=%b%b%b%b expected cyc=%0d data=%h dv/pe/se/bd=%b%b%b%b",
               tag, i, dut_q[i].cyc, dut_q[i].data, dut_q[i].dv, dut_q[i].pe, dut_q[i].se, dut_q[i].bd,
               exp_q[i].cyc, exp_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].bd);
      end
    end
  endtask

  task automatic ev_chk(input string tag, input int idx, input logic [7:0] data,
                        input logic [3:0] flags, input int cyc);
    chk({tag, "_present"}, 64'(dut_q.size() > idx), 64'd1);
    if (dut_q.size() > idx) begin
      chk({tag, "_data"}, 64'(dut_q[idx].data), 64'(data));
      chk({tag, "_flags"}, 64'({dut_q[idx].dv, dut_q[idx].pe, dut_q[idx].se, dut_q[idx].bd}), 64'(flags));
      if (cyc >= 0) chk({tag, "_cycle"}, 64'(dut_q[idx].cyc), 64'(cyc));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
    end
  endtask

  task automatic begin_seg();
    @(posedge CLK); #1;
    RX_IN = 1'b1;
    dut_q.delete();
    line_q.delete();
    cfg_q.delete();
    rec = 1'b1;
  endtask

  task automatic end_seg(input string tag);
    idle(1000);
    rec = 1'b0;
    run_model();
    compare(tag);
  endtask

  task automatic send_frame(input int pr, input int dl, input bit pe, input bit pt, input bit s2,
                            input logic [7:0] data, input bit flip, input bit bad1, input bit bad2,
                            input bit scr, input int abort_at);
    int p = (pr < 8) ? 8 : pr;
    int l = (dl < 5 || dl > 8) ? 8 : dl;
    int cyc = 0;
    logic par = pt;
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < l; i++) begin
      bits.push_back(data[i]);
      par ^= data[i];
    end
    if (pe) bits.push_back(par ^ flip);
    bits.push_back(!bad1);
    if (s2) bits.push_back(!bad2);
    foreach (bits[k]) begin
      for (int j = 0; j < p; j++) begin
        if (abort_at >= 0 && cyc == abort_at) return;
        @(posedge CLK); #1;
        RX_IN = bits[k];
        if (cyc == 0) begin
          prescale = 6'(pr); data_len = 4'(dl); PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
        end else if (scr) begin
          prescale = 6'($urandom); data_len = 4'($urandom); PAR_EN = 1'($urandom);
          PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
        end
        cyc++;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pulses_busy", 64'({data_valid, par_err, stp_err, break_det, busy}), 64'd0);
    chk("rst_rx_data", 64'(rx_data), 64'd0);
    RST = 1'b1;
    idle(5);

    // 8N1 at prescale 8
    begin_seg();
    send_frame(8, 8, 0, 0, 0, 8'hA5, 0, 0, 0, 0, -1);
    end_seg("a5_frame");
    ev_chk("a5", 0, 8'hA5, 4'b1000, 81);

    // 7 bits, odd parity, wrong parity bit
    begin_seg();
    send_frame(16, 7, 1, 1, 0, 8'h3C, 1, 0, 0, 0, -1);
    end_seg("parity_err");
    ev_chk("par", 0, 8'h3C, 4'b0100, 161);

    // two stop bits, second one low
    begin_seg();
    send_frame(8, 8, 0, 0, 1, 8'h5A, 0, 0, 1, 0, -1);
    end_seg("stop2_err");
    ev_chk("stp", 0, 8'h5A, 4'b0010, -1);

    // 3-cycle glitch is rejected
    begin_seg();
    prescale = 6'd8; data_len = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      RX_IN = 1'b0;
    end
    end_seg("glitch");
    chk("glitch_no_pulse", 64'(dut_q.size()), 64'd0);

    // good frame, then 12 bit times of low line
    begin_seg();
    send_frame(8, 8, 1, 0, 0, 8'h42, 0, 0, 0, 0, -1);
    idle(5);
    prescale = 6'd8; data_len = 4'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    repeat (96) begin
      @(posedge CLK); #1;
      RX_IN = 1'b0;
    end
    end_seg("break");
    ev_chk("brk_prev", 0, 8'h42, 4'b1000, -1);
    ev_chk("brk", 1, 8'h42, 4'b0011, -1);

    // back-to-back frames with no idle gap
    begin_seg();
    send_frame(16, 8, 0, 0, 0, 8'h11, 0, 0, 0, 0, -1);
    send_frame(16, 8, 0, 0, 0, 8'hEE, 0, 0, 0, 0, -1);
    end_seg("b2b");
    ev_chk("b2b0", 0, 8'h11, 4'b1000, 161);
    ev_chk("b2b1", 1, 8'hEE, 4'b1000, 321);

    // randomized frames, config scrambled mid-frame, random errors and gaps
    for (int seg = 0; seg < 3; seg++) begin
      begin_seg();
      repeat (10) begin
        send_frame(($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(8, 40),
                   $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 4) == 0), 1'b1, -1);
        idle(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20));
      end
      end_seg("random");
    end

    // reset during frame bit 4
    begin_seg();
    send_frame(8, 8, 0, 0, 0, 8'h5B, 0, 0, 0, 0, 35);
    @(posedge CLK); #1;
    RX_IN = 1'b1;
    RST = 1'b0;
    #1;
    chk("midrst_pulses_busy", 64'({data_valid, par_err, stp_err, break_det, busy}), 64'd0);
    chk("midrst_rx_data", 64'(rx_data), 64'd0);
    rec = 1'b0;
    chk("midrst_no_pulse", 64'(dut_q.size()), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    model_rx = 8'h00;
    begin_seg();
    send_frame(12, 8, 1, 0, 1, 8'h96, 0, 0, 0, 0, -1);
    end_seg("post_rst");
    ev_chk("post_rst", 0, 8'h96, 4'b1000, 1 + 12 * 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl_gen2.md
UART_RX_CTRL_GEN2 -- requirements
Module: uart_rx_ctrl_gen2

Interface
REQ-001 SHALL have parameter MAX_DATA_W, default 8, meaning the widest supported frame payload (legal values 5..9).
REQ-002 SHALL have parameter PRESCALE_W, default 6, meaning the width of the oversampling prescale input.
REQ-003 SHALL have port CLK, input, 1, oversampling clock.
REQ-004 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port RX_IN, input, 1, serial line, already synchronised, idle high.
REQ-006 SHALL have port prescale, input, PRESCALE_W, number of CLK cycles per bit.
REQ-007 SHALL have port data_len, input, 4, payload bits per frame (5..MAX_DATA_W).
REQ-008 SHALL have port PAR_EN, input, 1, enables the parity bit.
REQ-009 SHALL have port PAR_TYP, input, 1, parity type (0 even, 1 odd).
REQ-010 SHALL have port STOP2, input, 1, selects two stop bits (1) or one (0).
REQ-011 SHALL have port rx_data, output, MAX_DATA_W, received payload, LSB first, upper unused bits 0.
REQ-012 SHALL have ports data_valid, par_err, stp_err and break_det, each output, 1, single-cycle status pulses.
REQ-013 SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY, STOP_A, STOP_B and DONE.
REQ-015 On an IDLE cycle with RX_IN=0, the block SHALL enter START with edge_cnt loaded to 1 and SHALL latch prescale, data_len, PAR_EN, PAR_TYP and STOP2; later changes to these inputs SHALL be ignored until the next IDLE or DONE exit.
REQ-016 A latched prescale below 8 SHALL be treated as 8; a data_len outside 5..MAX_DATA_W SHALL be treated as MAX_DATA_W.
REQ-017 edge_cnt SHALL count 0..P-1 within each bit (P = latched prescale) and wrap to 0; bit_cnt SHALL increment on each wrap.
REQ-018 Each bit value SHALL be the 2-of-3 majority of RX_IN sampled at edge_cnt = P/2-1, P/2 and P/2+1, using integer division.
REQ-019 At the end of START (edge_cnt=P-1), the block SHALL go to DATA if the majority value is 0, otherwise to IDLE with no output pulse (glitch rejection).
REQ-020 In DATA, the block SHALL shift each majority bit into position bit_cnt of a shift register and leave DATA after data_len bits, going to PARITY if PAR_EN=1, otherwise to STOP_A.
REQ-021 PARITY SHALL compare the sampled bit with the XOR of the received payload XOR PAR_TYP; a mismatch SHALL set an internal par_flag.
REQ-022 STOP_A, and STOP_B when STOP2=1, SHALL set an internal stp_flag if the sampled bit is 0; STOP_A SHALL go to STOP_B when STOP2=1, otherwise to DONE.
REQ-023 DONE SHALL last exactly 1 cycle, during which:
- rx_data SHALL be updated with the payload, held until the next DONE;
- data_valid=1 if neither flag is set;
- par_err=par_flag; stp_err=stp_flag.
REQ-024 Break condition: payload all 0, parity bit 0 (if enabled) and first stop bit 0. On a break, DONE SHALL assert break_det=1 and stp_err=1 with data_valid=0, and rx_data SHALL be left unchanged.
REQ-025 From DONE, the block SHALL go to START (same rules as REQ-015) if RX_IN=0, otherwise to IDLE, supporting back-to-back frames with zero idle cycles.
REQ-026 The block SHALL leave STOP_A or STOP_B at edge_cnt=P-1 of the stop bit, so that data_valid occurs 1 cycle after the last stop bit period ends.
REQ-027 The block SHALL have no other output activity; all pulse outputs SHALL be 0 outside DONE.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-029 While RST=0, the block SHALL hold state IDLE, edge_cnt=0, bit_cnt=0, flags=0, rx_data=0, all pulses=0 and busy=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no status pulse; after release the block SHALL wait for the next falling edge on RX_IN.

Verification
REQ-031 prescale=8, data_len=8, PAR_EN=0, STOP2=0, send 0xA5 -> data_valid pulse 1 cycle after the stop bit, rx_data=0xA5, no errors.
REQ-032 prescale=16, data_len=7, PAR_EN=1, PAR_TYP=1, send 0x3C with a wrong parity bit -> par_err=1 and data_valid=0 in DONE; rx_data=0x3C.
REQ-033 STOP2=1, second stop bit driven 0 -> stp_err=1, data_valid=0; a 3-cycle low glitch with prescale=8 -> return to IDLE, no pulses.
REQ-034 RX_IN held low for 12 bit times with data_len=8, PAR_EN=1 -> break_det=1, stp_err=1, rx_data unchanged from the previous frame.
REQ-035 Two frames 0x11 and 0xEE sent back-to-back with no idle gap -> two data_valid pulses spaced exactly 10*P cycles apart.
REQ-036 RST pulsed low during bit 4 of a frame -> outputs zero immediately; the next full frame is received correctly.
